// File: rtl/ngcore_seq.sv
// Multi-cycle sequencer: fetch, optional *A read, execute handshake, optional *A write.
// Data instr 1 cycle, compute 2, +1 per *A access; stalls on imem_valid, dmem_rvalid, dmem_wack.
module ngcore_seq (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] dmem_addr,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic [15:0] dmem_wdata,
  output logic        dmem_we,
  input  logic        dmem_wack,
  output logic [15:0] h_instr,
  output logic [15:0] h_a_reg,
  output logic [15:0] h_d_reg,
  output logic [15:0] h_a_mem_reg,
  input  logic [15:0] h_out,
  input  logic        h_jmp,
  input  logic [2:0]  h_dst,
  output logic [15:0] instret
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] areg_q, areg_d;
  logic [15:0] dreg_q, dreg_d;
  logic [15:0] mreg_q, mreg_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] instret_q, instret_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (imem_valid && imem_data[15]) state_d = imem_data[12] ? S_READ : S_EXEC;
      S_READ:  if (dmem_rvalid) state_d = S_EXEC;
      S_EXEC:  state_d = h_dst[0] ? S_WRITE : S_FETCH;
      S_WRITE: if (dmem_wack) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Datapath next-state; EXEC uses the pre-update A for both jump target and write address.
  always_comb begin
    pc_d      = pc_q;
    areg_d    = areg_q;
    dreg_d    = dreg_q;
    mreg_d    = mreg_q;
    ir_d      = ir_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    instret_d = instret_q;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          if (!imem_data[15]) begin
            areg_d    = imem_data;
            pc_d      = pc_q + 16'd1;
            instret_d = instret_q + 16'd1;
          end else begin
            ir_d = imem_data;
          end
        end
      end
      S_READ: begin
        if (dmem_rvalid) mreg_d = dmem_rdata;
      end
      S_EXEC: begin
        pc_d = h_jmp ? areg_q : pc_q + 16'd1;
        if (h_dst[2]) areg_d = h_out;
        if (h_dst[1]) dreg_d = h_out;
        if (h_dst[0]) begin
          wr_addr_d = areg_q;
          wr_data_d = h_out;
        end else begin
          instret_d = instret_q + 16'd1;
        end
      end
      S_WRITE: begin
        if (dmem_wack) instret_d = instret_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= 16'd0;
      areg_q    <= 16'd0;
      dreg_q    <= 16'd0;
      mreg_q    <= 16'd0;
      ir_q      <= 16'd0;
      wr_addr_q <= 16'd0;
      wr_data_q <= 16'd0;
      instret_q <= 16'd0;
    end else begin
      pc_q      <= pc_d;
      areg_q    <= areg_d;
      dreg_q    <= dreg_d;
      mreg_q    <= mreg_d;
      ir_q      <= ir_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    dmem_we     = (state_q == S_WRITE);
    dmem_addr   = dmem_we ? wr_addr_q : areg_q;
    dmem_wdata  = wr_data_q;
    imem_addr   = pc_q;
    h_instr     = ir_q;
    h_a_reg     = areg_q;
    h_d_reg     = dreg_q;
    h_a_mem_reg = mreg_q;
    instret     = instret_q;
  end

endmodule
